// File: rtl/rob_pkg.sv
// Shared reorder-buffer types, sizes, fault causes and the completion-merge helper.
// Fault fields exist only when ROB_XCPT_EN is defined.
package rob_pkg;

  localparam int ROB_ENTRIES = 8;
  localparam int ROB_ID_W    = $clog2(ROB_ENTRIES);

  // Fault causes, shared with regFile.
  localparam logic [2:0] XCPT_NONE        = 3'd0;
  localparam logic [2:0] XCPT_ILLEGAL     = 3'd1;
  localparam logic [2:0] XCPT_MISALIGNED  = 3'd2;
  localparam logic [2:0] XCPT_LOAD_FAULT  = 3'd3;
  localparam logic [2:0] XCPT_STORE_FAULT = 3'd4;
  localparam logic [2:0] XCPT_OVERFLOW    = 3'd5;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
`ifdef ROB_XCPT_EN
    logic        xcpt;
    logic [2:0]  xcpt_type;
    logic [31:0] xcpt_addr;
`endif
  } rob_entry_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
`ifdef ROB_XCPT_EN
    logic        xcpt;
    logic [2:0]  xcpt_type;
    logic [31:0] xcpt_addr;
`endif
  } rob_done_t;

  function automatic rob_entry_t complete_entry(rob_entry_t e, rob_done_t d);
    rob_entry_t r;
    r      = e;
    r.done = 1'b1;
    r.we   = d.we;
    r.dest = d.dest;
    r.data = d.data;
`ifdef ROB_XCPT_EN
    r.xcpt      = d.xcpt;
    r.xcpt_type = d.xcpt_type;
    r.xcpt_addr = d.xcpt_addr;
`endif
    return r;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Decode/execute/commit bus of the reorder buffer; slave is the ROB, master the pipeline.
interface rob_commit_ctrl_if #(parameter int ROB_ID_W = rob_pkg::ROB_ID_W);
  logic                alloc_valid;
  logic [31:0]         alloc_pc;
  logic [ROB_ID_W-1:0] alloc_id;
  logic                rob_full;
  logic                rob_empty;

  logic                alu_done_valid, mul_done_valid;
  logic [ROB_ID_W-1:0] alu_done_id, mul_done_id;
  logic                alu_done_we, mul_done_we;
  logic [4:0]          alu_done_dest, mul_done_dest;
  logic [31:0]         alu_done_data, mul_done_data;
  logic                alu_done_xcpt, mul_done_xcpt;
  logic [2:0]          alu_done_xcpt_type, mul_done_xcpt_type;
  logic [31:0]         alu_done_xcpt_addr, mul_done_xcpt_addr;

  logic                writeEnRF;
  logic [31:0]         writeValRF;
  logic [4:0]          destRF;
  logic [ROB_ID_W-1:0] write_idRF;
  logic                xcpt_valid;
  logic [31:0]         rmPC;
  logic [31:0]         rmAddr;
  logic [2:0]          xcpt_type;
  logic                flush_rob;

  modport slave (
    input  alloc_valid, alloc_pc,
    input  alu_done_valid, alu_done_id, alu_done_we, alu_done_dest, alu_done_data,
    input  alu_done_xcpt, alu_done_xcpt_type, alu_done_xcpt_addr,
    input  mul_done_valid, mul_done_id, mul_done_we, mul_done_dest, mul_done_data,
    input  mul_done_xcpt, mul_done_xcpt_type, mul_done_xcpt_addr,
    output alloc_id, rob_full, rob_empty,
    output writeEnRF, writeValRF, destRF, write_idRF,
    output xcpt_valid, rmPC, rmAddr, xcpt_type, flush_rob
  );

  modport master (
    output alloc_valid, alloc_pc,
    output alu_done_valid, alu_done_id, alu_done_we, alu_done_dest, alu_done_data,
    output alu_done_xcpt, alu_done_xcpt_type, alu_done_xcpt_addr,
    output mul_done_valid, mul_done_id, mul_done_we, mul_done_dest, mul_done_data,
    output mul_done_xcpt, mul_done_xcpt_type, mul_done_xcpt_addr,
    input  alloc_id, rob_full, rob_empty,
    input  writeEnRF, writeValRF, destRF, write_idRF,
    input  xcpt_valid, rmPC, rmAddr, xcpt_type, flush_rob
  );
endinterface

// File: rtl/rob_storage.sv
// ROB entry array: allocate port, two completion ports (ALU has priority), head read, flush-clear.
// Per-entry fault fields are present only with ROB_XCPT_EN.
module rob_storage import rob_pkg::*; #(
  parameter int ROB_ENTRIES = rob_pkg::ROB_ENTRIES,
  parameter int ROB_ID_W    = rob_pkg::ROB_ID_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic [ROB_ID_W-1:0] alloc_idx,
  input  logic [31:0]         alloc_pc,
  input  logic                alu_en,
  input  logic [ROB_ID_W-1:0] alu_idx,
  input  rob_done_t           alu_done,
  input  logic                mul_en,
  input  logic [ROB_ID_W-1:0] mul_idx,
  input  rob_done_t           mul_done,
  input  logic                retire_en,
  input  logic                flush,
  input  logic [ROB_ID_W-1:0] head_idx,
  output rob_entry_t          head_entry
);

  rob_entry_t entry_q [ROB_ENTRIES];
  rob_entry_t entry_d [ROB_ENTRIES];

  always_comb begin
    // NOTE: start from the current array so every path assigns entry_d; otherwise a latch is inferred.
    entry_d = entry_q;
    if (flush) begin
      for (int i = 0; i < ROB_ENTRIES; i++) entry_d[i].valid = 1'b0;
    end else begin
      if (retire_en) entry_d[head_idx].valid = 1'b0;
      if (alloc_en) begin
        entry_d[alloc_idx]       = '0;
        entry_d[alloc_idx].valid = 1'b1;
        entry_d[alloc_idx].pc    = alloc_pc;
      end
      // Merge onto entry_d so a retire clear is never undone; ALU is applied last and wins a collision.
      if (mul_en && entry_q[mul_idx].valid) entry_d[mul_idx] = complete_entry(entry_d[mul_idx], mul_done);
      if (alu_en && entry_q[alu_idx].valid) entry_d[alu_idx] = complete_entry(entry_d[alu_idx], alu_done);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset as a whole because stale valid bits would otherwise commit after reset.
      for (int i = 0; i < ROB_ENTRIES; i++) entry_q[i] <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign head_entry = entry_q[head_idx];

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order commit scheduler: pointers, occupancy and registered commit/exception pulses.
// Define ROB_XCPT_EN to enable fault storage and the exception/flush path.
module rob_commit_ctrl import rob_pkg::*; #(
  parameter int ROB_ENTRIES = rob_pkg::ROB_ENTRIES,
  parameter int ROB_ID_W    = rob_pkg::ROB_ID_W
) (
  input logic              clock,
  input logic              reset,
  rob_commit_ctrl_if.slave bus
);

  rob_entry_t          head_entry;
  rob_done_t           alu_done, mul_done;
  logic [ROB_ID_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_ID_W:0]   count_q, count_d;
  logic                alloc_en, commit_en, commit_xcpt, flush_active;

  logic                write_en_q, write_en_d;
  logic [31:0]         write_val_q, write_val_d;
  logic [4:0]          dest_q, dest_d;
  logic [ROB_ID_W-1:0] write_id_q, write_id_d;

  assign bus.alloc_id  = tail_q;
  assign bus.rob_full  = (count_q == (ROB_ID_W+1)'(ROB_ENTRIES));
  assign bus.rob_empty = (count_q == '0);

  always_comb begin
    alu_done      = '0;
    alu_done.we   = bus.alu_done_we;
    alu_done.dest = bus.alu_done_dest;
    alu_done.data = bus.alu_done_data;
    mul_done      = '0;
    mul_done.we   = bus.mul_done_we;
    mul_done.dest = bus.mul_done_dest;
    mul_done.data = bus.mul_done_data;
`ifdef ROB_XCPT_EN
    alu_done.xcpt      = bus.alu_done_xcpt;
    alu_done.xcpt_type = bus.alu_done_xcpt_type;
    alu_done.xcpt_addr = bus.alu_done_xcpt_addr;
    mul_done.xcpt      = bus.mul_done_xcpt;
    mul_done.xcpt_type = bus.mul_done_xcpt_type;
    mul_done.xcpt_addr = bus.mul_done_xcpt_addr;
`endif
  end

  rob_storage #(.ROB_ENTRIES(ROB_ENTRIES), .ROB_ID_W(ROB_ID_W)) u_storage (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_idx  (tail_q),
    .alloc_pc   (bus.alloc_pc),
    .alu_en     (bus.alu_done_valid),
    .alu_idx    (bus.alu_done_id),
    .alu_done   (alu_done),
    .mul_en     (bus.mul_done_valid),
    .mul_idx    (bus.mul_done_id),
    .mul_done   (mul_done),
    .retire_en  (commit_en),
    .flush      (flush_active),
    .head_idx   (head_q),
    .head_entry (head_entry)
  );

  // The flush cycle drops allocations and completions and holds off any further commit.
  assign alloc_en  = bus.alloc_valid & ~bus.rob_full & ~flush_active;
  assign commit_en = head_entry.valid & head_entry.done & ~flush_active;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    write_en_d  = 1'b0;
    write_val_d = '0;
    dest_d      = '0;
    write_id_d  = '0;
    if (flush_active) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + ROB_ID_W'(commit_en);
      tail_d  = tail_q + ROB_ID_W'(alloc_en);
      count_d = count_q + (ROB_ID_W+1)'(alloc_en) - (ROB_ID_W+1)'(commit_en);
    end
    if (commit_en && !commit_xcpt) begin
      write_en_d  = head_entry.we;
      write_val_d = head_entry.data;
      dest_d      = head_entry.dest;
      write_id_d  = head_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      write_en_q  <= 1'b0;
      write_val_q <= '0;
      dest_q      <= '0;
      write_id_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      write_en_q  <= write_en_d;
      write_val_q <= write_val_d;
      dest_q      <= dest_d;
      write_id_q  <= write_id_d;
    end
  end

  assign bus.writeEnRF  = write_en_q;
  assign bus.writeValRF = write_val_q;
  assign bus.destRF     = dest_q;
  assign bus.write_idRF = write_id_q;

`ifdef ROB_XCPT_EN
  logic        xcpt_valid_q, xcpt_valid_d;
  logic [31:0] rm_pc_q, rm_pc_d, rm_addr_q, rm_addr_d;
  logic [2:0]  xcpt_type_q, xcpt_type_d;
  logic        flush_rob_q, flush_rob_d;

  assign commit_xcpt  = commit_en & head_entry.xcpt;
  assign flush_active = flush_rob_q;

  always_comb begin
    xcpt_valid_d = commit_xcpt;
    flush_rob_d  = commit_xcpt;
    rm_pc_d      = commit_xcpt ? head_entry.pc        : '0;
    rm_addr_d    = commit_xcpt ? head_entry.xcpt_addr : '0;
    xcpt_type_d  = commit_xcpt ? head_entry.xcpt_type : XCPT_NONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xcpt_valid_q <= 1'b0;
      rm_pc_q      <= '0;
      rm_addr_q    <= '0;
      xcpt_type_q  <= XCPT_NONE;
      flush_rob_q  <= 1'b0;
    end else begin
      xcpt_valid_q <= xcpt_valid_d;
      rm_pc_q      <= rm_pc_d;
      rm_addr_q    <= rm_addr_d;
      xcpt_type_q  <= xcpt_type_d;
      flush_rob_q  <= flush_rob_d;
    end
  end

  assign bus.xcpt_valid = xcpt_valid_q;
  assign bus.rmPC       = rm_pc_q;
  assign bus.rmAddr     = rm_addr_q;
  assign bus.xcpt_type  = xcpt_type_q;
  assign bus.flush_rob  = flush_rob_q;
`else
  logic xcpt_unused;

  assign commit_xcpt  = 1'b0;
  assign flush_active = 1'b0;
  assign xcpt_unused  = ^{bus.alu_done_xcpt, bus.alu_done_xcpt_type, bus.alu_done_xcpt_addr,
                          bus.mul_done_xcpt, bus.mul_done_xcpt_type, bus.mul_done_xcpt_addr,
                          head_entry.pc};

  assign bus.xcpt_valid = 1'b0;
  assign bus.rmPC       = '0;
  assign bus.rmAddr     = '0;
  assign bus.xcpt_type  = '0;
  assign bus.flush_rob  = 1'b0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scoreboard bench for rob_commit_ctrl; the exception scenario follows ROB_XCPT_EN.
module tb_rob_commit_ctrl;
  import rob_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rob_commit_ctrl_if #(.ROB_ID_W(3)) bus ();

  rob_commit_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        wen;
    logic [2:0]  id;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        xcpt;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [2:0]  typ;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock)
    if (!reset)
      assert (!(bus.alu_done_valid && bus.mul_done_valid && bus.alu_done_id == bus.mul_done_id))
        else $error("protocol: ALU and MUL complete the same id %0d", bus.alu_done_id);

  // Monitor: every commit pulse is matched against the next expected retirement.
  always @(negedge clock) begin
    if (!reset && (bus.writeEnRF || bus.xcpt_valid || bus.flush_rob)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 32'(bus.writeEnRF | bus.xcpt_valid | bus.flush_rob), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("writeEnRF", 32'(bus.writeEnRF), 32'(mon_e.wen));
        check("xcpt_valid", 32'(bus.xcpt_valid), 32'(mon_e.xcpt));
        check("flush_rob", 32'(bus.flush_rob), 32'(mon_e.xcpt));
        if (mon_e.wen) begin
          check("writeValRF", bus.writeValRF, mon_e.data);
          check("destRF", 32'(bus.destRF), 32'(mon_e.dest));
          check("write_idRF", 32'(bus.write_idRF), 32'(mon_e.id));
        end
        if (mon_e.xcpt) begin
          check("rmPC", bus.rmPC, mon_e.pc);
          check("rmAddr", bus.rmAddr, mon_e.addr);
          check("xcpt_type", 32'(bus.xcpt_type), 32'(mon_e.typ));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid        = 1'b0;
    bus.alloc_pc           = '0;
    bus.alu_done_valid     = 1'b0;
    bus.alu_done_id        = '0;
    bus.alu_done_we        = 1'b0;
    bus.alu_done_dest      = '0;
    bus.alu_done_data      = '0;
    bus.alu_done_xcpt      = 1'b0;
    bus.alu_done_xcpt_type = '0;
    bus.alu_done_xcpt_addr = '0;
    bus.mul_done_valid     = 1'b0;
    bus.mul_done_id        = '0;
    bus.mul_done_we        = 1'b0;
    bus.mul_done_dest      = '0;
    bus.mul_done_data      = '0;
    bus.mul_done_xcpt      = 1'b0;
    bus.mul_done_xcpt_type = '0;
    bus.mul_done_xcpt_addr = '0;
  endtask

  task automatic drive_alu(input logic [2:0] id, input logic [4:0] dest, input logic [31:0] data,
                           input logic xcpt, input logic [2:0] typ, input logic [31:0] addr);
    bus.alu_done_valid     = 1'b1;
    bus.alu_done_id        = id;
    bus.alu_done_we        = 1'b1;
    bus.alu_done_dest      = dest;
    bus.alu_done_data      = data;
    bus.alu_done_xcpt      = xcpt;
    bus.alu_done_xcpt_type = typ;
    bus.alu_done_xcpt_addr = addr;
  endtask

  task automatic drive_mul(input logic [2:0] id, input logic [4:0] dest, input logic [31:0] data);
    bus.mul_done_valid = 1'b1;
    bus.mul_done_id    = id;
    bus.mul_done_we    = 1'b1;
    bus.mul_done_dest  = dest;
    bus.mul_done_data  = data;
  endtask

  task automatic expect_wr(input logic [2:0] id, input logic [4:0] dest, input logic [31:0] data);
    exp_q.push_back('{wen: 1'b1, id: id, dest: dest, data: data, xcpt: 1'b0, pc: '0, addr: '0, typ: '0});
  endtask

  task automatic expect_xcpt(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] typ);
    exp_q.push_back('{wen: 1'b0, id: '0, dest: '0, data: '0, xcpt: 1'b1, pc: pc, addr: addr, typ: typ});
  endtask

  task automatic alloc(input logic [31:0] pc);
    bus.alloc_valid = 1'b1;
    bus.alloc_pc    = pc;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_id"}, 32'(bus.alloc_id), 32'd0);
    check({tag, "_rob_full"}, 32'(bus.rob_full), 32'd0);
    check({tag, "_rob_empty"}, 32'(bus.rob_empty), 32'd1);
    check({tag, "_writeEnRF"}, 32'(bus.writeEnRF), 32'd0);
    check({tag, "_writeValRF"}, bus.writeValRF, 32'd0);
    check({tag, "_destRF"}, 32'(bus.destRF), 32'd0);
    check({tag, "_write_idRF"}, 32'(bus.write_idRF), 32'd0);
    check({tag, "_xcpt_valid"}, 32'(bus.xcpt_valid), 32'd0);
    check({tag, "_rmPC"}, bus.rmPC, 32'd0);
    check({tag, "_flush_rob"}, 32'(bus.flush_rob), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t0;
    idle();
    #12;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // In-order completion: done at edge E, writeEnRF high after E+1.
    for (int i = 0; i < 4; i++) alloc(32'h100 + 32'(4 * i));
    check("rob_empty_live", 32'(bus.rob_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive_alu(3'(i), 5'(i + 1), 32'h10 + 32'(i), 1'b0, '0, '0);
      expect_wr(3'(i), 5'(i + 1), 32'h10 + 32'(i));
      tick();
      if (i == 0) check("latency_edge_e", 32'(bus.writeEnRF), 32'd0);
      if (i == 1) check("latency_edge_e1", 32'(bus.writeEnRF), 32'd1);
    end
    idle();
    drain(10);
    check("inorder_empty", 32'(bus.rob_empty), 32'd1);

    // Out-of-order completion: nothing retires until the oldest is done.
    t0 = bus.alloc_id;
    for (int i = 0; i < 3; i++) alloc(32'h200 + 32'(4 * i));
    drive_alu(t0 + 3'd2, 5'd7, 32'h22, 1'b0, '0, '0);
    tick();
    idle();
    drive_mul(t0 + 3'd1, 5'd6, 32'h21);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ooo_hold", 32'(bus.writeEnRF), 32'd0);
    end
    drive_alu(t0, 5'd5, 32'h20, 1'b0, '0, '0);
    expect_wr(t0, 5'd5, 32'h20);
    expect_wr(t0 + 3'd1, 5'd6, 32'h21);
    expect_wr(t0 + 3'd2, 5'd7, 32'h22);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ooo_back_to_back", 32'(bus.writeEnRF), 32'd1);
    end
    tick();
    check("ooo_end", 32'(bus.writeEnRF), 32'd0);
    drain(5);

    // Full and wrap-around from a clean start.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check("alloc_id_fill", 32'(bus.alloc_id), 32'(i));
      alloc(32'h300 + 32'(4 * i));
    end
    check("full_set", 32'(bus.rob_full), 32'd1);
    alloc(32'h0BAD);
    check("full_ignored_id", 32'(bus.alloc_id), 32'd0);
    check("full_still", 32'(bus.rob_full), 32'd1);
    drive_alu(3'd0, 5'd10, 32'hA0, 1'b0, '0, '0);
    expect_wr(3'd0, 5'd10, 32'hA0);
    tick();
    idle();
    check("full_done_pending", 32'(bus.rob_full), 32'd1);
    tick();
    check("full_cleared", 32'(bus.rob_full), 32'd0);
    check("wrap_alloc_id", 32'(bus.alloc_id), 32'd0);
    alloc(32'h400);
    check("refull", 32'(bus.rob_full), 32'd1);
    check("wrap_next_id", 32'(bus.alloc_id), 32'd1);

    // Same-cycle completion on both pipes, then drain the rest.
    drive_alu(3'd2, 5'd12, 32'hC2, 1'b0, '0, '0);
    drive_mul(3'd1, 5'd11, 32'hB1);
    expect_wr(3'd1, 5'd11, 32'hB1);
    expect_wr(3'd2, 5'd12, 32'hC2);
    tick();
    idle();
    for (int i = 3; i < 9; i++) begin
      drive_alu(3'(i), 5'(i + 10), 32'hD0 + 32'(i), 1'b0, '0, '0);
      expect_wr(3'(i), 5'(i + 10), 32'hD0 + 32'(i));
      tick();
    end
    idle();
    drain(20);
    check("wrap_empty", 32'(bus.rob_empty), 32'd1);

    t0 = bus.alloc_id;
`ifdef ROB_XCPT_EN
    // Fault on the middle entry: oldest commits, then exception and flush; youngest is discarded.
    alloc(32'h100);
    alloc(32'h104);
    alloc(32'h108);
    drive_alu(t0 + 3'd1, 5'd7, 32'h55, 1'b1, XCPT_LOAD_FAULT, 32'hDEAD0000);
    drive_mul(t0 + 3'd2, 5'd8, 32'h66);
    tick();
    idle();
    drive_alu(t0, 5'd6, 32'h44, 1'b0, '0, '0);
    expect_wr(t0, 5'd6, 32'h44);
    expect_xcpt(32'h104, 32'hDEAD0000, XCPT_LOAD_FAULT);
    tick();
    idle();
    drain(10);
    tick();
    check("flush_empty", 32'(bus.rob_empty), 32'd1);
    check("flush_alloc_id", 32'(bus.alloc_id), 32'd0);
    check("flush_no_write", 32'(bus.writeEnRF), 32'd0);
`else
    // Fault inputs are ignored: a faulting completion commits as a normal write.
    alloc(32'h200);
    drive_alu(t0, 5'd9, 32'h99, 1'b1, XCPT_LOAD_FAULT, 32'hDEAD0000);
    expect_wr(t0, 5'd9, 32'h99);
    tick();
    idle();
    drain(10);
    check("noxcpt_empty", 32'(bus.rob_empty), 32'd1);
    check("noxcpt_alloc_id", 32'(bus.alloc_id), 32'(t0 + 3'd1));
`endif

    // Asynchronous reset with five entries live and a commit pulse in flight.
    t0 = bus.alloc_id;
    for (int i = 0; i < 7; i++) alloc(32'h500 + 32'(4 * i));
    drive_alu(t0, 5'd3, 32'h70, 1'b0, '0, '0);
    expect_wr(t0, 5'd3, 32'h70);
    tick();
    idle();
    tick();
    drive_alu(t0 + 3'd1, 5'd4, 32'h77, 1'b0, '0, '0);
    tick();
    idle();
    tick();
    check("pre_reset_pulse", 32'(bus.writeEnRF), 32'd1);
    check("pre_reset_live", 32'(bus.rob_empty), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    #2;
    reset = 1'b0;
    tick();
    tick();
    check("post_reset_quiet", 32'(bus.writeEnRF), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

In-order commit scheduler for the 8-entry reorder buffer. Decode allocates its instruction IDs here, and the ALU and MUL pipes return out-of-order completions here. The block then retires entries strictly in program order, driving the single register-file write port (`writeEnRF`/`writeValRF`/`destRF`/`write_idRF`) and the exception/flush signals consumed by decode and the register file. It produces decode's `stall_decode` full condition and the `flush_rob` pulse.

## Interface
Parameters:
- `ROB_ENTRIES`, default 8: number of entries; power of two.
- `ROB_ID_W`, default 3: equals log2(`ROB_ENTRIES`); width of every ID.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `alloc_valid` in 1: decode issues an instruction this cycle.
- `alloc_pc` in 32: PC of the issued instruction.
- `alloc_id` out `ROB_ID_W`: current tail; the ID assigned to the allocation.
- `rob_full` out 1: occupancy equals `ROB_ENTRIES`; feeds decode's stall.
- `rob_empty` out 1: occupancy is 0.
- `alu_done_valid` in 1: ALU completion strobe.
- `alu_done_id` in `ROB_ID_W`: ID of the completing ALU instruction.
- `alu_done_we` in 1: ALU result writes the RF.
- `alu_done_dest` in 5: ALU destination register.
- `alu_done_data` in 32: ALU result.
- `alu_done_xcpt` in 1: ALU instruction faulted.
- `alu_done_xcpt_type` in 3: ALU fault cause.
- `alu_done_xcpt_addr` in 32: ALU faulting address.
- `mul_done_*`: same seven signals as the `alu_done_*` group, for the MUL pipe.
- `writeEnRF` out 1: commit write strobe.
- `writeValRF` out 32: commit write data.
- `destRF` out 5: commit destination register.
- `write_idRF` out `ROB_ID_W`: ID of the committing entry.
- `xcpt_valid` out 1: exception commit pulse.
- `rmPC` out 32: PC of the faulting instruction.
- `rmAddr` out 32: faulting address.
- `xcpt_type` out 3: fault cause.
- `flush_rob` out 1: pipeline flush pulse.

## Operation
- Each entry holds: `valid`, `done`, `we`, `dest`, `data`, `pc`, `xcpt`, `xcpt_type`, `xcpt_addr`. Head/tail pointers are `ROB_ID_W` bits and wrap naturally. Occupancy count spans 0..`ROB_ENTRIES`.
- Allocation: when `alloc_valid & !rob_full`, the entry at tail loads `valid=1`, `done=0`, `pc=alloc_pc`, and tail increments. `alloc_valid` while full is ignored; decode must hold the instruction.
- Completion: a done strobe to a `valid` entry sets `done` and loads the payload. A strobe to an invalid entry is ignored. ALU and MUL may complete different IDs in the same cycle. If both target the same ID, the ALU wins; this is a protocol error, and a bench assertion must flag it.
- Commit: if the head entry is `valid & done`, it retires on the next edge, at most one entry per cycle. Retiring clears `valid`, advances head, and decrements the count.
  - Non-fault: `writeEnRF = we`, with `writeValRF`/`destRF`/`write_idRF` taken from the entry.
  - Fault: `writeEnRF=0`; `xcpt_valid=1`, `rmPC=pc`, `rmAddr`, `xcpt_type`; `flush_rob=1`.
- Flush: in the cycle after a fault commits, all `valid` bits clear and head=tail=0, count=0. Any allocation or completion in the flush cycle is dropped.
- Simultaneous allocate and commit: the count is unchanged. `rob_full` is computed from the registered count, so a full ROB accepts no allocation even in a cycle where it commits.

## Timing
- Reset values: `alloc_id=0`, `rob_full=0`, `rob_empty=1`, and all commit/exception/flush outputs 0.
- `alloc_id`, `rob_full`, and `rob_empty` are combinational from registered state.
- Commit outputs are registered one-cycle pulses.
- Completion latency: a done strobe sampled at edge E sets `done`. If the entry is at head, the commit outputs are high for the cycle after edge E+1. Minimum latency from done to `writeEnRF` is 2 cycles.
- Back-to-back commits are sustained at one per cycle.
- A reset asserted mid-operation clears everything immediately (asynchronous). No partial commit pulse survives.

## Configuration
- `ROB_XCPT_EN` defined: fault fields are stored per entry and the exception/flush path behaves as described above.
- `ROB_XCPT_EN` undefined:
  - `*_done_xcpt*` inputs are ignored and no `xcpt*` storage exists.
  - `xcpt_valid`, `rmPC`, `rmAddr`, `xcpt_type`, and `flush_rob` are tied to 0.
  - Every done entry commits as a normal write.

## Structure
- Package `rob_pkg` holds: `ROB_ENTRIES`, `ROB_ID_W`, the `rob_entry_t` struct, and the xcpt cause localparams (shared with `regFile`).
- One sub-module, `rob_storage`: the entry array with an allocate write port, two completion write ports, a head read port, and flush-clear.
- Pointers, count, and commit logic live in `rob_commit_ctrl`.

## Test plan
- In-order completion: allocate IDs 0..3 with data 0x10..0x13, dest r1..r4, completing in order → four consecutive `writeEnRF` pulses with values 0x10..0x13 and `write_idRF` 0..3.
- Out-of-order completion: allocate 0,1,2, then complete 2, 1, 0 → no commit until ID 0 is done; then commits 0,1,2 on three consecutive cycles.
- Full and wrap-around: allocate 8 → `rob_full=1` and a 9th `alloc_valid` is ignored. Complete ID 0 → after its commit, `rob_full=0`. The next allocation receives `alloc_id=0` (wrap).
- Same-cycle completion: ALU completes ID 1 and MUL completes ID 0 in one cycle → commits ID 0 then ID 1; both values are correct.
- Exception (with `ROB_XCPT_EN`): ID 1 faults with type 3, addr 0xDEAD0000, pc 0x104 → ID 0 commits normally. Next, `xcpt_valid=1`, `rmPC=0x104`, `rmAddr=0xDEAD0000`, `flush_rob=1`, and `writeEnRF=0`. Then `rob_empty=1` and `alloc_id=0`.
- Mid-operation reset: assert `reset` with 5 entries live → all outputs immediately return to reset values, and `rob_empty=1`.
